// File: rtl/multicycle_control.sv
// Control FSM for a shared-memory multicycle MIPS datapath.
// Sequences R-type, LW, SW, BEQ, BNE and J over 3-5 states, with
// memory wait states driven by MemReady.
// Optional macro MULTICYCLE_ADDI_EN adds ADDI (ADDIEX -> ADDIWB).
module multicycle_control #(
  parameter bit RESET_STATE_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       XorBne,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWE,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       InstrDone,
  output logic       IllegalOp
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10
`ifdef MULTICYCLE_ADDI_EN
    , ADDIEX = 4'd11
    , ADDIWB = 4'd12
`endif
  } state_t;

  state_t     state, nextState;
  logic [5:0] opReg;
  logic       illegalReg;
  logic       opIllegal;
  logic       opRegIsSw;

  // Opcode held from DECODE so later states ignore whatever is on OpCode.
  assign opRegIsSw = (opReg == OP_SW);

  // Classify the live opcode; only meaningful while in DECODE.
  always_comb begin
    opIllegal = 1'b1;
    case (OpCode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: opIllegal = 1'b0;
`ifdef MULTICYCLE_ADDI_EN
      OP_ADDI: opIllegal = 1'b0;
`endif
      default: opIllegal = 1'b1;
    endcase
  end

  // State register; reset destination selected by parameter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE_IDLE ? IDLE : FETCH;
    else        state <= nextState;
  end

  // Opcode capture and sticky illegal-opcode flag, both updated in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opReg      <= '0;
      illegalReg <= 1'b0;
    end else if (state == DECODE) begin
      opReg <= OpCode;
      if (opIllegal) illegalReg <= 1'b1;
    end
  end

  // Next-state and control outputs (Moore, with MemReady-gated Mealy terms).
  always_comb begin
    nextState   = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    XorBne      = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWE       = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSrc       = 2'b00;
    InstrDone   = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        ALUOp     = 3'b001;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        nextState = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b001;
        case (OpCode)
          OP_LW, OP_SW:   nextState = MEMADR;
          OP_RTYPE:       nextState = EXEC;
          OP_BEQ, OP_BNE: nextState = BRANCH;
          OP_J:           nextState = JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:        nextState = ADDIEX;
`endif
          default:        nextState = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 3'b001;
        nextState = opRegIsSw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nextState = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWE     = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        nextState = MemReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWE     = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b010;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        XorBne      = opReg[0];
        InstrDone   = 1'b1;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSrc     = 2'b10;
        InstrDone = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 3'b001;
        nextState = ADDIWB;
      end
      ADDIWB: begin
        RegWE     = 1'b1;
        InstrDone = 1'b1;
      end
`endif
      default: nextState = FETCH;
    endcase
    // Keep every strobe quiet while reset is held, whatever the reset state.
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      XorBne      = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWE       = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 3'b000;
      PCSrc       = 2'b00;
      InstrDone   = 1'b0;
    end
  end

  assign IllegalOp = illegalReg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control words from the instruction-level rules, then
// replayed against the DUT with random opcodes on the don't-care cycles.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, XorBne, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWE, ALUSrcA, InstrDone, IllegalOp;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOp;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pcw, pcwc, xb, iord, mrd, mwr, irw, m2r, rdst, rwe, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] psrc;
    logic       done, ill;
  } outs_t;

  typedef struct {
    outs_t      exp;
    logic       mr;
    logic [5:0] op;
  } step_t;

  step_t q[$];
  logic  illFlag;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .XorBne(XorBne),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWE(RegWE), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  function automatic outs_t observed();
    outs_t o;
    o = {PCWrite, PCWriteCond, XorBne, IorD, MemRead, MemWrite, IRWrite,
         MemToReg, RegDst, RegWE, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
         InstrDone, IllegalOp};
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t got;
    got = observed();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    checks++;
    assert (!(MemRead && MemWrite) && !(RegWE && MemWrite)) else begin
      errors++;
      $error("FAIL %s_exclusive observed rd/wr/we=%b%b%b expected no overlap",
             tag, MemRead, MemWrite, RegWE);
    end
  endtask

  function automatic outs_t blank();
    outs_t c;
    c = '0;
    c.ill = illFlag;
    return c;
  endfunction

  task automatic push(input outs_t c, input logic mr, input logic [5:0] op);
    step_t s;
    s.exp = c;
    s.mr  = mr;
    s.op  = op;
    q.push_back(s);
  endtask

  // Expand one instruction into expected cycles. wf / wd = number of
  // not-ready cycles for the fetch and the data access respectively.
  task automatic build(input logic [5:0] op, input int wf, input int wd);
    outs_t c;
    logic  legal;
    for (int i = 0; i <= wf; i++) begin
      c = blank();
      c.mrd = 1; c.asb = 2'b01; c.aop = 3'b001;
      c.irw = (i == wf); c.pcw = (i == wf);
      push(c, i == wf, 6'($urandom));
    end
    c = blank();
    c.asb = 2'b11; c.aop = 3'b001;
    push(c, 1'($urandom), op);
    legal = 1'b1;
    case (op)
      6'b100011, 6'b101011: begin
        c = blank(); c.asa = 1; c.asb = 2'b10; c.aop = 3'b001;
        push(c, 1'($urandom), 6'($urandom));
        for (int i = 0; i <= wd; i++) begin
          c = blank(); c.iord = 1;
          if (op == 6'b100011) c.mrd = 1;
          else begin c.mwr = 1; c.done = (i == wd); end
          push(c, i == wd, 6'($urandom));
        end
        if (op == 6'b100011) begin
          c = blank(); c.rwe = 1; c.m2r = 1; c.done = 1;
          push(c, 1'($urandom), 6'($urandom));
        end
      end
      6'b000000: begin
        c = blank(); c.asa = 1;
        push(c, 1'($urandom), 6'($urandom));
        c = blank(); c.rwe = 1; c.rdst = 1; c.done = 1;
        push(c, 1'($urandom), 6'($urandom));
      end
      6'b000100, 6'b000101: begin
        c = blank(); c.asa = 1; c.aop = 3'b010; c.pcwc = 1; c.psrc = 2'b01;
        c.done = 1; c.xb = op[0];
        push(c, 1'($urandom), 6'($urandom));
      end
      6'b000010: begin
        c = blank(); c.pcw = 1; c.psrc = 2'b10; c.done = 1;
        push(c, 1'($urandom), 6'($urandom));
      end
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: begin
        c = blank(); c.asa = 1; c.asb = 2'b10; c.aop = 3'b001;
        push(c, 1'($urandom), 6'($urandom));
        c = blank(); c.rwe = 1; c.done = 1;
        push(c, 1'($urandom), 6'($urandom));
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) illFlag = 1'b1;
  endtask

  // Replay up to n expected cycles; inputs set after negedge, outputs
  // sampled 1 time unit later.
  task automatic play(input string tag, input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && k < n) begin
      s = q.pop_front();
      @(negedge clk);
      MemReady = s.mr;
      OpCode   = s.op;
      #1;
      check($sformatf("%s_c%0d", tag, k), s.exp);
      k++;
    end
  endtask

  initial begin
    logic [5:0] pool [8];
    logic [5:0] op;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
             6'b000101, 6'b000010, 6'b001000, 6'b111111};
    illFlag  = 1'b0;
    rst_n    = 1'b0;
    OpCode   = 6'b100011;
    MemReady = 1'b1;

    // All outputs zero while reset held
    repeat (2) @(negedge clk);
    #1 check("reset_hold", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle", '0);

    // LW, no waits: 5 cycles
    build(6'b100011, 0, 0);
    play("lw", 100);
    // SW with 3 wait cycles in MEMWR
    build(6'b101011, 0, 3);
    play("sw_wait", 100);
    // BNE then BEQ
    build(6'b000101, 0, 0);
    play("bne", 100);
    build(6'b000100, 1, 0);
    play("beq", 100);
    // Illegal opcode, then R-type with IllegalOp sticky
    build(6'b111111, 0, 0);
    play("illegal", 100);
    build(6'b000000, 0, 0);
    play("rtype_after_ill", 100);
    // J, and the ADDI opcode (legal only with the feature built in)
    build(6'b000010, 2, 0);
    play("jump", 100);
    build(6'b001000, 0, 0);
    play("addi", 100);

    // Reset during MEMWR wait: MemWrite must drop immediately
    build(6'b101011, 0, 3);
    play("sw_pre_rst", 5);
    q.delete();
    #2 rst_n = 1'b0;
    #1 check("async_rst", '0);
    illFlag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_after_rst", '0);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 7)];
      build(op, $urandom_range(0, 2), $urandom_range(0, 2));
      play($sformatf("rnd%0d_op%b", i, op), 100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
